// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer
// Turns a raw, bouncing, active-low push-button into three clean registered
// signals: a debounced level (pressed) and one-cycle press/release strobes.
// The input passes through a 2-flop synchronizer. A 4-state debounce FSM then
// accepts a change only after DEBOUNCE_CYCLES consecutive stable samples.
// Optional build macro: KEY_PULSE_AUTO_REPEAT_EN. When defined, press_pulse
// also fires REPEAT_DELAY cycles after the initial press and then every
// REPEAT_PERIOD cycles while the key stays held.
module key_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int RPT_W           = 25
) (
  input  logic clock,
  input  logic reset_b,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("key_pulse_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("key_pulse_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_rpt
    $error("key_pulse_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
  if (((longint'(1) << RPT_W) <= longint'(REPEAT_DELAY)) ||
      ((longint'(1) << RPT_W) <= longint'(REPEAT_PERIOD))) begin : g_bad_rpt_w
    $error("key_pulse_debouncer: RPT_W too narrow for the repeat timing");
  end

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

  // Terminal count of the qualification counter; it never counts past this.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             k_s;

  state_t           state_r;
  state_t           state_nx_s;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             cnt_last_s;

  logic             pressed_r;
  logic             press_pulse_r;
  logic             release_pulse_r;
  logic             pressed_nx_s;
  logic             press_pulse_nx_s;
  logic             release_pulse_nx_s;

  logic             repeat_fire_s;

  // Two-flop synchronizer on the inverted key; reset value is "released"
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
    end
  end

  assign k_s        = sync2_r;
  assign cnt_last_s = (cnt_r == DB_LAST);

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic: a bounce in a wait state falls back without a pulse
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (k_s) begin
          state_nx_s = ST_PRESS_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!k_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_last_s) begin
          state_nx_s = ST_HELD;
        end else begin
          state_nx_s = ST_PRESS_WAIT;
        end
      end
      ST_HELD: begin
        if (!k_s) begin
          state_nx_s = ST_RELEASE_WAIT;
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (k_s) begin
          state_nx_s = ST_HELD;
        end else if (cnt_last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RELEASE_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM output/datapath logic: next values of the counter and registered outputs
  always_comb begin
    cnt_nx_s           = '0;
    pressed_nx_s       = 1'b0;
    press_pulse_nx_s   = 1'b0;
    release_pulse_nx_s = 1'b0;

    // The counter only advances while staying in a wait state, so it is
    // cleared on every state entry and stops at DB_LAST (the exit condition).
    if (((state_r == ST_PRESS_WAIT) && (state_nx_s == ST_PRESS_WAIT)) ||
        ((state_r == ST_RELEASE_WAIT) && (state_nx_s == ST_RELEASE_WAIT))) begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nx_s = '0;
    end

    if ((state_nx_s == ST_HELD) || (state_nx_s == ST_RELEASE_WAIT)) begin
      pressed_nx_s = 1'b1;
    end else begin
      pressed_nx_s = 1'b0;
    end

    if ((state_r == ST_PRESS_WAIT) && (state_nx_s == ST_HELD)) begin
      press_pulse_nx_s = 1'b1;
    end else begin
      press_pulse_nx_s = repeat_fire_s;
    end

    if ((state_r == ST_RELEASE_WAIT) && (state_nx_s == ST_IDLE)) begin
      release_pulse_nx_s = 1'b1;
    end else begin
      release_pulse_nx_s = 1'b0;
    end
  end

  // Qualification counter and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      cnt_r           <= '0;
      pressed_r       <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
    end else begin
      cnt_r           <= cnt_nx_s;
      pressed_r       <= pressed_nx_s;
      press_pulse_r   <= press_pulse_nx_s;
      release_pulse_r <= release_pulse_nx_s;
    end
  end

`ifdef KEY_PULSE_AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_r;
  logic [RPT_W-1:0] rpt_nx_s;
  logic             rpt_periodic_r;
  logic             rpt_periodic_nx_s;

  // Auto-repeat timing: first interval is REPEAT_DELAY, then REPEAT_PERIOD.
  // Anything other than staying in HELD clears it, so it restarts at 0 on
  // the cycle the initial press pulse fires and on every re-entry to HELD.
  always_comb begin
    rpt_nx_s          = '0;
    rpt_periodic_nx_s = 1'b0;
    repeat_fire_s     = 1'b0;
    if ((state_r == ST_HELD) && (state_nx_s == ST_HELD)) begin
      if (!rpt_periodic_r) begin
        if (rpt_r == RPT_DELAY_LAST) begin
          repeat_fire_s     = 1'b1;
          rpt_nx_s          = '0;
          rpt_periodic_nx_s = 1'b1;
        end else begin
          rpt_nx_s          = rpt_r + RPT_W'(1);
          rpt_periodic_nx_s = 1'b0;
        end
      end else begin
        if (rpt_r == RPT_PERIOD_LAST) begin
          repeat_fire_s = 1'b1;
          rpt_nx_s      = '0;
        end else begin
          rpt_nx_s      = rpt_r + RPT_W'(1);
        end
        rpt_periodic_nx_s = 1'b1;
      end
    end else begin
      rpt_nx_s          = '0;
      rpt_periodic_nx_s = 1'b0;
      repeat_fire_s     = 1'b0;
    end
  end

  // Auto-repeat counter and phase register
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      rpt_r          <= '0;
      rpt_periodic_r <= 1'b0;
    end else begin
      rpt_r          <= rpt_nx_s;
      rpt_periodic_r <= rpt_periodic_nx_s;
    end
  end
`else
  assign repeat_fire_s = 1'b0;
`endif

  assign pressed       = pressed_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;

endmodule

// File: doc/key_pulse_debouncer.md
Name: key_pulse_debouncer

Overview:
- Conditions a raw, active-low, bouncing push-button (KEY) into clean signals for the 8-bit counter stage: a debounced pressed level plus one-cycle press and release pulses.
- Sits directly upstream of the counter. press_pulse drives its clock-enable/step input, which replaces wiring KEY[0] straight to the counter clock.
- Runs on the board clock: 2-flop synchronizer, then a debounce FSM with a qualification counter.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a change (10 ms at 50 MHz). Must be >= 1.
- CNT_W, 20: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 25000000: cycles in HELD before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).
- RPT_W, 25: width of the repeat counter. Must cover max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clock, input, 1: system clock (50 MHz board clock); all logic on its rising edge.
- reset_b, input, 1: synchronous active-low reset.
- key_n, input, 1: raw push-button, asynchronous, 0 = pressed.
- pressed, output, 1: debounced level, 1 = key accepted as held.
- press_pulse, output, 1: one-cycle strobe on accepted press (and on auto-repeat when enabled).
- release_pulse, output, 1: one-cycle strobe on accepted release.

Behaviour:
- Reset (reset_b sampled 0 at a rising edge): state IDLE; debounce counter 0; repeat counter 0; synchronizer flops set to the released value. pressed, press_pulse and release_pulse are all 0.
- Reset mid-operation aborts any pending qualification; no pulse is emitted for it.
- Synchronizer: 2 flops on the inverted key_n, giving k_s (1 = pressed). The FSM uses only k_s.
- FSM, 4 states:
  - IDLE (pressed=0): k_s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT (pressed=0):
    - k_s=0 -> IDLE (bounce rejected, no pulse).
    - else if cnt==DEBOUNCE_CYCLES-1 -> HELD, press_pulse<=1, pressed<=1.
    - else cnt<=cnt+1.
  - HELD (pressed=1): k_s=0 -> RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT (pressed=1):
    - k_s=1 -> HELD (release bounce rejected, no new press_pulse).
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse<=1, pressed<=0.
    - else cnt<=cnt+1.
- Latency: let edge 0 be the first edge that samples key_n=0, with key_n held low thereafter. FSM enters PRESS_WAIT at edge 2. press_pulse and pressed rise at edge DEBOUNCE_CYCLES+2. press_pulse falls at edge DEBOUNCE_CYCLES+3. Release is symmetric for release_pulse/pressed.
- All outputs are registered. press_pulse and release_pulse are never high in the same cycle. Each is high for exactly 1 cycle per event.
- Counter never wraps: it is cleared on every state entry and stops at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: KEY_PULSE_AUTO_REPEAT_EN.
- Defined:
  - In HELD, the repeat counter starts at 0 on the cycle press_pulse fires.
  - An extra press_pulse fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while in HELD.
  - The repeat counter is cleared on leaving HELD, including a bounce into RELEASE_WAIT.
  - pressed is unaffected.
- Undefined: no repeat counter is built; press_pulse fires once per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset: reset_b=0 for 2 edges with key_n=0 -> pressed=0, press_pulse=0, release_pulse=0. After reset_b=1 with key_n still 0, press_pulse fires at edge 6 counted from the first edge with reset_b=1.
- Clean press: key_n low from edge 0 -> press_pulse=1 only in the cycle after edge 6; pressed=1 from edge 6.
- Press bounce: key_n 0 for 3 samples, 1 for 1 sample, then 0 held -> no pulse from the first burst; press_pulse at edge 6 counted from the final falling sample.
- Release with bounce: while held, key_n 1 for 2 samples, 0 for 1, then 1 held -> pressed stays 1 through the bounce, no extra press_pulse; release_pulse 6 edges after the final rising sample, then pressed=0.
- Reset mid-qualification: reset_b=0 at edge 4 of a press -> no press_pulse; state IDLE; qualification restarts after reset.
- Auto-repeat (macro defined): key_n held low 30 edges -> press_pulse at edges 6, 16, 19, 22, 25, 28. Without the macro -> a single pulse at edge 6.
